// File: rtl/serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder sequencer. Two WIDTH-bit operands and a carry-in are
// summed LSB-first through one shared full-adder cell. The cell is built from
// two half-adder stages and a carry register, and is reused for every bit.
// The final result is presented on registered outputs with a one-cycle done
// pulse.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, the block gains an i_sub input (two's-complement subtract)
//   and an o_ovf output (signed overflow).
//
// Parameters
//   WIDTH    operand/result width in bits (2..32)
//
// Ports
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   i_start  request, sampled only in IDLE
//   i_a      operand A, latched on the accepting edge
//   i_b      operand B, latched on the accepting edge
//   i_cin    carry-in, latched on the accepting edge
//   i_sub    (SERIAL_ADDER_SUB_EN) subtract request, latched with the operands
//   o_busy   high in RUN and DONE
//   o_done   one-cycle completion pulse
//   o_sum    registered result, held until the next completion
//   o_cout   registered final carry, held with o_sum
//   o_ovf    (SERIAL_ADDER_SUB_EN) registered signed overflow, held with o_sum
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; operands are latched on the accepting edge
// RUN   | one bit per clock, LSB first, for WIDTH clocks
// DONE  | result registered, o_done high for this single cycle
//------------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
  output logic             o_ovf,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_r;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic             w_p;
  logic             w_g;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_r_next;

`ifdef SERIAL_ADDER_SUB_EN
  logic r_ovf;

  // Subtract is a + ~b + 1; the caller's carry-in is ignored in that mode.
  assign w_b_load = i_sub ? ~i_b : i_b;
  assign w_c_load = i_sub ? 1'b1 : i_cin;
  assign o_ovf    = r_ovf;
`else
  assign w_b_load = i_b;
  assign w_c_load = i_cin;
`endif

  // Shared full-adder cell: first half adder on the operand bits, second
  // half adder folds in the carry register.
  assign w_p      = r_sa[0] ^ r_sb[0];
  assign w_g      = r_sa[0] & r_sb[0];
  assign w_s      = w_p ^ r_c;
  assign w_c      = w_g | (w_p & r_c);
  assign w_r_next = {w_s, r_r[WIDTH-1:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_r     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_sa    <= i_a;
            r_sb    <= w_b_load;
            r_c     <= w_c_load;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_r  <= w_r_next;
          r_sa <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb <= {1'b0, r_sb[WIDTH-1:1]};
          r_c  <= w_c;
          if (r_cnt == LAST) begin
            // Counter parks at zero so it never wraps past WIDTH-1.
            r_cnt   <= '0;
            r_sum   <= w_r_next;
            r_cout  <= w_c;
`ifdef SERIAL_ADDER_SUB_EN
            // r_c here is the carry into the MSB, w_c the carry out of it.
            r_ovf   <= r_c ^ w_c;
`endif
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic         ovf;
`endif

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub   (sub),
    .o_ovf   (ovf),
`endif
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    exp_t         e;
  } vec_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  logic [W-1:0] last_sum = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    exp_t         r;
    bb    = ms ? ~mb : mb;
    cc    = ms ? 1'b1 : mc;
    full  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, cc};
    r.sum = full[W-1:0];
    r.cout = full[W];
    r.ovf = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return r;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sbq.size() == 0) begin
        chk(1'b0, "unexpected_done", 32'(sum), 32'(0));
      end else begin
        e = sbq.pop_front();
        chk(sum == e.sum, "sum", 32'(sum), 32'(e.sum));
        chk(cout == e.cout, "cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_SUB_EN
        chk(ovf == e.ovf, "ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input exp_t e);
    int  k;
    bit  seen;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk);
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk(busy == 1'b1, "busy_after_accept", 32'(busy), 32'(1));
    seen = 1'b0;
    for (k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      chk(sum == last_sum, "sum_hold", 32'(sum), 32'(last_sum));
      chk(busy == 1'b1, "busy_run", 32'(busy), 32'(1));
    end
    chk(seen && k == W, "latency", 32'(k), 32'(W));
    if (seen) begin
      last_sum = e.sum;
      chk(busy == 1'b1, "busy_in_done", 32'(busy), 32'(1));
      @(negedge clk);
      chk(!busy && !done, "busy_done_fall", {30'd0, busy, done}, 32'(0));
    end
  endtask

  vec_t tbl[7];
  int   tms[3];

  initial begin
    tbl[0] = '{8'h3C, 8'h05, 1'b0, 1'b0, '{8'h41, 1'b0, 1'b0}};
    tbl[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b0}};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, '{8'hFF, 1'b1, 1'b0}};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b1}};
    tbl[4] = '{8'h01, 8'h01, 1'b0, 1'b0, '{8'h02, 1'b0, 1'b0}};
    tbl[5] = '{8'hA5, 8'h5A, 1'b0, 1'b0, '{8'hFF, 1'b0, 1'b0}};
    tbl[6] = '{8'h7F, 8'h01, 1'b1, 1'b0, '{8'h81, 1'b0, 1'b1}};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(!busy && !done && sum == 0 && !cout, "reset_outputs",
          {23'd0, busy, done, cout, sum}, 32'(0));
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk(!busy && !done && sum == 0 && !cout, "idle_outputs",
          {23'd0, busy, done, cout, sum}, 32'(0));
    end

    for (int i = 0; i < 7; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].e);

    // Second request 3 cycles into RUN must be dropped.
    begin
      int  k;
      bit  seen;
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      sbq.push_back('{8'h02, 1'b0, 1'b0});
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'h10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk(busy == 1'b1, "busy_ignore", 32'(busy), 32'(1));
      seen = 1'b0;
      for (k = 0; k < W + 4; k++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      chk(seen, "ignore_done_seen", 32'(seen), 32'(1));
      last_sum = 8'h02;
      repeat (12) @(negedge clk);
      chk(sum == 8'h02, "ignore_sum_kept", 32'(sum), 32'(8'h02));
    end

    // start held high: back-to-back operations, done pulses 10 cycles apart.
    begin
      int n;
      int cyc;
      exp_t e;
      e = model(8'h12, 8'h34, 1'b0, 1'b0);
      repeat (3) sbq.push_back(e);
      n = 0; cyc = 0;
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      for (int t = 0; t < 60 && n < 3; t++) begin
        @(negedge clk);
        cyc++;
        if (done) begin
          tms[n] = cyc;
          n++;
        end
      end
      start = 1'b0;
      chk(n == 3, "b2b_count", 32'(n), 32'(3));
      chk(tms[1] - tms[0] == W + 2, "b2b_gap1", 32'(tms[1] - tms[0]), 32'(W + 2));
      chk(tms[2] - tms[1] == W + 2, "b2b_gap2", 32'(tms[2] - tms[1]), 32'(W + 2));
      last_sum = e.sum;
      repeat (3) @(negedge clk);
    end

    // Reset 4 cycles into RUN aborts with no done pulse.
    begin
      int dc;
      @(negedge clk);
      a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      dc = done_cnt;
      rst_n = 1'b0;
      #1;
      chk(!busy && !done, "abort_busy", {30'd0, busy, done}, 32'(0));
      chk(sum == 0 && !cout, "abort_sum", {23'd0, cout, sum}, 32'(0));
      last_sum = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      chk(done_cnt == dc, "abort_no_done", 32'(done_cnt - dc), 32'(0));
      run_op(8'h80, 8'h80, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b1});
    end

    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, '{8'hFE, 1'b0, 1'b0});
    run_op(8'h80, 8'h01, 1'b1, 1'b1, '{8'h7F, 1'b1, 1'b1});
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      run_op(ra, rb, 1'b0, 1'b1, model(ra, rb, 1'b0, 1'b1));
    end
`endif

    repeat (2) @(negedge clk);
    chk(sbq.size() == 0, "scoreboard_drain", 32'(sbq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder sequencer. It accepts two WIDTH-bit operands plus carry-in and sums them LSB-first through a single one-bit full-adder cell built from two half-adder stages and a carry register, reusing that cell for every bit position. It presents the registered result with a one-cycle done pulse. It sits between a requesting master (start/busy/done handshake) and the shared one-bit adder datapath, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- cin  input  1  carry-in; latched when start is accepted.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse; high in the DONE state.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered final carry; holds with sum.

## Operation
- States: IDLE, RUN, DONE (binary-encoded).
- IDLE: on clk edge with start=1, do all of the following:
  - Latch a into shift register SA, b into SB, cin into the carry register C.
  - Clear the bit counter cnt to 0.
  - Go to RUN.
- RUN: each edge computes s = SA[0]^SB[0]^C and c = SA[0]&SB[0] | C&(SA[0]^SB[0]). Then:
  - Shift s into the MSB of the internal result shift register R.
  - Shift SA and SB right by one.
  - Set C = c and cnt = cnt + 1.
  - On the edge where cnt == WIDTH-1, also load sum from the shifted R value, load cout from c, and go to DONE.
- DONE: unconditionally go to IDLE on the next edge.
- Width rules:
  - cnt is clog2(WIDTH) bits wide and never exceeds WIDTH-1.
  - sum is the modulo-2^WIDTH result of a+b+cin.
  - cout is bit WIDTH of that result.
- start is ignored in RUN and DONE. No queueing; the request is dropped, not deferred.
- Operand inputs are don't-care outside the accepting edge.

## Timing
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, sum=0, cout=0, internal SA/SB/R/C/cnt=0.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately and no done pulse follows.
- Call the accepting edge E0:
  - busy rises after E0.
  - Bits are processed on edges E1..EWIDTH.
  - done, sum and cout update after EWIDTH.
  - done falls and busy falls after E(WIDTH+1).
- Latency from start acceptance to done is WIDTH cycles. done is high for exactly 1 cycle.
- The earliest next acceptance is E(WIDTH+2), so throughput is one operation per WIDTH+2 cycles when start is held high.
- start held continuously high starts back-to-back operations, each separated by the single IDLE cycle.
- sum/cout are stable from the done cycle until the next op's done edge. The intermediate R value is never visible on sum.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds input port sub (1 bit), latched with the operands.
  - When sub=1, SB is loaded with ~b and C with 1, ignoring cin. sum = a−b mod 2^WIDTH, and cout = 1 means no borrow.
  - Also adds output ovf (1 bit): signed overflow, computed as carry-into-MSB XOR carry-out-of-MSB. ovf is registered with sum, resets to 0 and holds like sum.
- SERIAL_ADDER_SUB_EN undefined: ports sub and ovf do not exist, and the block is add-only.

## Test plan
- Reset then idle:
  - rst_n low 3 cycles, then release with start=0 for 20 cycles.
  - Expect busy=0, done=0, sum=0, cout=0 throughout.
- Basic add, WIDTH=8:
  - a=8'h3C, b=8'h05, cin=0, start for 1 cycle.
  - Expect done exactly 8 cycles after acceptance, sum=8'h41, cout=0, busy high for 9 cycles.
- Full carry chain:
  - a=8'hFF, b=8'h00, cin=1.
  - Expect sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1, expect sum=8'hFF, cout=1.
- Ignored start and back-to-back:
  - Pulse start with a=8'h01, b=8'h01, then pulse start again 3 cycles later with a=8'h10.
  - The second request is ignored; only sum=8'h02 is produced.
  - Then hold start high: the next done pulses are spaced 10 cycles apart.
- Reset mid-operation:
  - Deassert rst_n 4 cycles into RUN.
  - Expect busy=0 and sum=0 immediately, and no done pulse.
  - A fresh op a=8'h80, b=8'h80 then gives sum=8'h00, cout=1.
- With SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=8'h05, b=8'h07: expect sum=8'hFE, cout=0, ovf=0.
  - sub=1, a=8'h80, b=8'h01: expect sum=8'h7F, cout=1, ovf=1.
